// File: rtl/m00_axi_be_slave_mem_responder.sv
// AXI4 slave memory responder for the M00 backend: INCR bursts into a local
// byte-strobed memory, with independent read and write engines.
module m00_axi_be_slave_mem_responder #(
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned DATA_W    = 512,
  parameter int unsigned ID_W      = 1,
  parameter int unsigned MEM_DEPTH = 1024
) (
  input  logic                ap_clk,
  input  logic                aresetn,
  // write address
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic [3:0]          awcache,
  input  logic [2:0]          awprot,
  input  logic [3:0]          awqos,
  input  logic                awlock,
  input  logic [3:0]          awregion,
  input  logic                awvalid,
  output logic                awready,
  // write data
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  // write response
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  // read address
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [7:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic [3:0]          arcache,
  input  logic [2:0]          arprot,
  input  logic [3:0]          arqos,
  input  logic                arlock,
  input  logic [3:0]          arregion,
  input  logic                arvalid,
  output logic                arready,
  // read data
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = ADDR_W - 6;
  localparam int unsigned MIDX_W = $clog2(MEM_DEPTH);
  localparam int unsigned CHK_W  = IDX_W + 1;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rd_state_e;

  // Legal = INCR, full-width beats, and the whole burst fits in memory.
  function automatic logic req_legal(input logic [1:0] burst, input logic [2:0] size,
                                     input logic [IDX_W-1:0] idx, input logic [7:0] len);
    logic [CHK_W-1:0] span;
    span = CHK_W'(idx) + CHK_W'(len);
    return (burst == 2'b01) && (size == 3'b110) && (span < CHK_W'(MEM_DEPTH));
  endfunction

  // Sideband and sub-word address bits carry no meaning for this target.
  logic unused_sideband_c;
  assign unused_sideband_c = ^{awcache, awprot, awqos, awlock, awregion, awaddr[5:0],
                               arcache, arprot, arqos, arlock, arregion, araddr[5:0]};

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  // ---------------- write engine ----------------
  wr_state_e         wr_state_q, wr_state_d;
  logic [ID_W-1:0]   wr_id_q, wr_id_d;
  logic [MIDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [7:0]        wr_len_q, wr_len_d;
  logic [7:0]        wr_cnt_q, wr_cnt_d;
  logic              wr_err_q, wr_err_d;
  logic              wr_over_q, wr_over_d;
  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic [ID_W-1:0]   bid_q, bid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              mem_we_c;

  // Write state and registered write-side outputs.
  always_ff @(posedge ap_clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state_q <= W_IDLE;
      wr_id_q    <= '0;
      wr_idx_q   <= '0;
      wr_len_q   <= '0;
      wr_cnt_q   <= '0;
      wr_err_q   <= 1'b0;
      wr_over_q  <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bid_q      <= '0;
      bresp_q    <= 2'b00;
    end else begin
      wr_state_q <= wr_state_d;
      wr_id_q    <= wr_id_d;
      wr_idx_q   <= wr_idx_d;
      wr_len_q   <= wr_len_d;
      wr_cnt_q   <= wr_cnt_d;
      wr_err_q   <= wr_err_d;
      wr_over_q  <= wr_over_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bid_q      <= bid_d;
      bresp_q    <= bresp_d;
    end
  end

  // Write next-state: accept AW, absorb beats until wlast, then hold B.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_id_d    = wr_id_q;
    wr_idx_d   = wr_idx_q;
    wr_len_d   = wr_len_q;
    wr_cnt_d   = wr_cnt_q;
    wr_err_d   = wr_err_q;
    wr_over_d  = wr_over_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bid_d      = bid_q;
    bresp_d    = bresp_q;
    mem_we_c   = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (awvalid && awready_q) begin
          wr_state_d = W_DATA;
          wr_id_d    = awid;
          wr_idx_d   = MIDX_W'(awaddr[ADDR_W-1:6]);
          wr_len_d   = awlen;
          wr_cnt_d   = 8'd0;
          wr_err_d   = !req_legal(awburst, awsize, awaddr[ADDR_W-1:6], awlen);
          wr_over_d  = 1'b0;
          awready_d  = 1'b0;
          wready_d   = 1'b1;
        end
      end
      W_DATA: begin
        if (wvalid && wready_q) begin
          // Beats past len are swallowed without touching memory.
          mem_we_c = !wr_err_q && !wr_over_q;
          wr_idx_d = wr_idx_q + MIDX_W'(1);
          if (wlast) begin
            wr_state_d = W_RESP;
            wready_d   = 1'b0;
            bvalid_d   = 1'b1;
            bid_d      = wr_id_q;
            bresp_d    = (wr_err_q || wr_over_q || (wr_cnt_q != wr_len_q)) ? 2'b10 : 2'b00;
          end else begin
            if (wr_cnt_q == wr_len_q) wr_over_d = 1'b1;
            wr_cnt_d = wr_cnt_q + 8'd1;
          end
        end
      end
      W_RESP: begin
        if (bvalid_q && bready) begin
          wr_state_d = W_IDLE;
          bvalid_d   = 1'b0;
          awready_d  = 1'b1;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Byte-strobed memory write; contents survive reset.
  always_ff @(posedge ap_clk) begin
    if (mem_we_c) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem_q[wr_idx_q][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // ---------------- read engine ----------------
  rd_state_e         rd_state_q, rd_state_d;
  logic [MIDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [7:0]        rd_len_q, rd_len_d;
  logic [7:0]        rd_cnt_q, rd_cnt_d;
  logic              rd_err_q, rd_err_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic              rlast_q, rlast_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [DATA_W-1:0] rdata_q;
  logic              rd_en_c;

  // Read state and registered read-side outputs.
  always_ff @(posedge ap_clk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state_q <= R_IDLE;
      rd_idx_q   <= '0;
      rd_len_q   <= '0;
      rd_cnt_q   <= '0;
      rd_err_q   <= 1'b0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rid_q      <= '0;
      rresp_q    <= 2'b00;
    end else begin
      rd_state_q <= rd_state_d;
      rd_idx_q   <= rd_idx_d;
      rd_len_q   <= rd_len_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_err_q   <= rd_err_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rlast_q    <= rlast_d;
      rid_q      <= rid_d;
      rresp_q    <= rresp_d;
    end
  end

  // Read next-state: one fetch cycle, then stream beats; read ahead only on a handshake.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_idx_d   = rd_idx_q;
    rd_len_d   = rd_len_q;
    rd_cnt_d   = rd_cnt_q;
    rd_err_d   = rd_err_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rlast_d    = rlast_q;
    rid_d      = rid_q;
    rresp_d    = rresp_q;
    rd_en_c    = (rd_state_q == R_FETCH) || (rvalid_q && rready && !rlast_q);
    case (rd_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (arvalid && arready_q) begin
          rd_state_d = R_FETCH;
          rd_idx_d   = MIDX_W'(araddr[ADDR_W-1:6]);
          rd_len_d   = arlen;
          rd_cnt_d   = 8'd0;
          rd_err_d   = !req_legal(arburst, arsize, araddr[ADDR_W-1:6], arlen);
          rid_d      = arid;
          rresp_d    = req_legal(arburst, arsize, araddr[ADDR_W-1:6], arlen) ? 2'b00 : 2'b10;
          arready_d  = 1'b0;
        end
      end
      R_FETCH: begin
        rd_state_d = R_DATA;
        rd_idx_d   = rd_idx_q + MIDX_W'(1);
        rvalid_d   = 1'b1;
        rlast_d    = (rd_cnt_q == rd_len_q);
      end
      R_DATA: begin
        if (rvalid_q && rready) begin
          if (rlast_q) begin
            rd_state_d = R_IDLE;
            rvalid_d   = 1'b0;
            rlast_d    = 1'b0;
            arready_d  = 1'b1;
          end else begin
            rd_cnt_d = rd_cnt_q + 8'd1;
            rd_idx_d = rd_idx_q + MIDX_W'(1);
            rlast_d  = ((rd_cnt_q + 8'd1) == rd_len_q);
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Registered memory read port; error bursts return zero data.
  always_ff @(posedge ap_clk or negedge aresetn) begin
    if (!aresetn) begin
      rdata_q <= '0;
    end else if (rd_en_c) begin
      rdata_q <= rd_err_q ? '0 : mem_q[rd_idx_q];
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rlast   = rlast_q;
  assign rid     = rid_q;
  assign rresp   = rresp_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_m00_axi_be_slave_mem_responder.sv
// Directed bench for the M00 AXI slave memory responder.
module tb_m00_axi_be_slave_mem_responder;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 512;
  localparam int unsigned ID_W   = 1;
  localparam int unsigned DEPTH  = 1024;

  logic                ap_clk, aresetn;
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic [3:0]          awcache, awqos, awregion;
  logic [2:0]          awprot;
  logic                awlock, awvalid, awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast, wvalid, wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid, bready;
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic [3:0]          arcache, arqos, arregion;
  logic [2:0]          arprot;
  logic                arlock, arvalid, arready;
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast, rvalid, rready;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] rd_data [0:255];
  logic [1:0]        rd_resp [0:255];
  logic              rd_last [0:255];

  m00_axi_be_slave_mem_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .MEM_DEPTH(DEPTH)
  ) dut (
    .ap_clk(ap_clk), .aresetn(aresetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awcache(awcache), .awprot(awprot), .awqos(awqos), .awlock(awlock), .awregion(awregion),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arcache(arcache), .arprot(arprot), .arqos(arqos), .arlock(arlock), .arregion(arregion),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check_eq(input string tag, input logic [DATA_W-1:0] obs,
                          input logic [DATA_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Full write transaction; beat k carries base+k (or all ones), wlast on last_beat.
  task automatic axi_write(input logic [ADDR_W-1:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [ID_W-1:0] id,
                           input int nbeats, input int last_beat,
                           input logic [DATA_W/8-1:0] strb, input logic [DATA_W-1:0] base,
                           input bit ones, input bit throttle, output logic [1:0] resp);
    int t;
    bit got;
    resp = 2'bxx;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = 3'b110; awvalid = 1'b1;
    t = 0;
    while (!awready && t < 100) begin tick(); t++; end
    if (!awready) begin check_eq("aw_timeout", 0, 1); awvalid = 1'b0; return; end
    tick();
    awvalid = 1'b0;
    check_eq("wready_after_aw", DATA_W'(wready), 1);
    for (int k = 0; k < nbeats; k++) begin
      wvalid = 1'b1;
      wdata  = ones ? '1 : base + DATA_W'(k);
      wstrb  = strb;
      wlast  = (k == last_beat);
      t = 0;
      while (!wready && t < 100) begin tick(); t++; end
      if (!wready) begin check_eq("w_timeout", 0, 1); wvalid = 1'b0; return; end
      tick();
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    check_eq("bvalid_after_wlast", DATA_W'(bvalid), 1);
    got = 1'b0;
    t = 0;
    while (!got && t < 200) begin
      bready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bvalid && bready) begin
        resp = bresp;
        check_eq("bid", DATA_W'(bid), DATA_W'(id));
        got = 1'b1;
      end
      tick();
      t++;
    end
    bready = 1'b0;
    if (!got) check_eq("b_timeout", 0, 1);
    else check_eq("awready_back_idle", DATA_W'(awready), 1);
  endtask

  // Full read transaction; beats land in rd_data/rd_resp/rd_last.
  task automatic axi_read(input logic [ADDR_W-1:0] addr, input logic [7:0] len,
                          input bit throttle, input bit chk_lat, output int nb);
    int t;
    bit done, stall;
    logic [DATA_W-1:0] prev;
    nb = 0;
    arid = 1'b1; araddr = addr; arlen = len; arburst = 2'b01; arsize = 3'b110; arvalid = 1'b1;
    t = 0;
    while (!arready && t < 100) begin tick(); t++; end
    if (!arready) begin check_eq("ar_timeout", 0, 1); arvalid = 1'b0; return; end
    tick();
    arvalid = 1'b0;
    if (chk_lat) begin
      check_eq("rvalid_n1_low", DATA_W'(rvalid), 0);
      tick();
      check_eq("rvalid_n2_high", DATA_W'(rvalid), 1);
    end
    done = 1'b0; stall = 1'b0; prev = '0; t = 0;
    while (!done && t < 2000) begin
      rready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rvalid && stall) check_eq("rdata_stable", rdata, prev);
      if (rvalid && rready) begin
        if (nb < 256) begin
          rd_data[nb] = rdata; rd_resp[nb] = rresp; rd_last[nb] = rlast;
        end
        nb++;
        if (rlast) done = 1'b1;
      end
      stall = rvalid && !rready;
      prev  = rdata;
      tick();
      t++;
    end
    rready = 1'b0;
    if (!done) check_eq("r_timeout", 0, 1);
  endtask

  logic [1:0] resp, resp_w;
  int nb, nb_r, t;
  logic [DATA_W-1:0] exp_d;

  initial begin
    ap_clk = 1'b0; aresetn = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = 3'b110; awburst = 2'b01;
    awcache = '0; awprot = '0; awqos = '0; awlock = 1'b0; awregion = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = 3'b110; arburst = 2'b01;
    arcache = '0; arprot = '0; arqos = '0; arlock = 1'b0; arregion = '0; arvalid = 1'b0;
    rready = 1'b0;

    // Reset values.
    repeat (3) tick();
    check_eq("rst_awready", DATA_W'(awready), 0);
    check_eq("rst_arready", DATA_W'(arready), 0);
    check_eq("rst_wready",  DATA_W'(wready), 0);
    check_eq("rst_bvalid",  DATA_W'(bvalid), 0);
    check_eq("rst_rvalid",  DATA_W'(rvalid), 0);
    check_eq("rst_rdata",   rdata, 0);
    aresetn = 1'b1;
    tick();
    check_eq("post_rst_awready", DATA_W'(awready), 1);
    check_eq("post_rst_arready", DATA_W'(arready), 1);

    // Basic burst: words 1..4 <= 1..4.
    axi_write(64'h40, 8'd3, 2'b01, 1'b1, 4, 3, '1, 512'd1, 1'b0, 1'b0, resp);
    check_eq("t1_bresp", DATA_W'(resp), 0);
    axi_read(64'h40, 8'd3, 1'b0, 1'b1, nb);
    check_eq("t1_nbeats", DATA_W'(nb), 4);
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("t1_rdata%0d", k), rd_data[k], DATA_W'(k + 1));
      check_eq($sformatf("t1_rresp%0d", k), DATA_W'(rd_resp[k]), 0);
      check_eq($sformatf("t1_rlast%0d", k), DATA_W'(rd_last[k]), DATA_W'(k == 3));
    end

    // Partial strobe on zeroed word 5.
    axi_write(64'h140, 8'd0, 2'b01, 1'b0, 1, 0, '1, 512'd0, 1'b0, 1'b0, resp);
    check_eq("t2_zero_bresp", DATA_W'(resp), 0);
    axi_write(64'h140, 8'd0, 2'b01, 1'b0, 1, 0, 64'h0000_0000_0000_000F, 512'd0, 1'b1, 1'b0, resp);
    check_eq("t2_strb_bresp", DATA_W'(resp), 0);
    axi_read(64'h140, 8'd0, 1'b0, 1'b0, nb);
    check_eq("t2_nbeats", DATA_W'(nb), 1);
    check_eq("t2_rdata", rd_data[0], 512'hFFFF_FFFF);

    // FIXED burst write is an error and must leave word 10 untouched.
    axi_write(64'h280, 8'd0, 2'b01, 1'b0, 1, 0, '1, 512'hAA, 1'b0, 1'b0, resp);
    axi_write(64'h280, 8'd0, 2'b00, 1'b1, 1, 0, '1, 512'd0, 1'b1, 1'b0, resp);
    check_eq("t3_bresp_err", DATA_W'(resp), 2);
    axi_read(64'h280, 8'd0, 1'b0, 1'b0, nb);
    check_eq("t3_mem_unchanged", rd_data[0], 512'hAA);

    // Read running off the end of memory: two error beats of zero.
    axi_read(64'(DEPTH - 1) << 6, 8'd1, 1'b0, 1'b0, nb);
    check_eq("t4_nbeats", DATA_W'(nb), 2);
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("t4_rresp%0d", k), DATA_W'(rd_resp[k]), 2);
      check_eq($sformatf("t4_rdata%0d", k), rd_data[k], 0);
      check_eq($sformatf("t4_rlast%0d", k), DATA_W'(rd_last[k]), DATA_W'(k == 1));
    end

    // Early wlast on beat 1 of len 3: error, beats 0-1 still written.
    axi_write(64'h500, 8'd3, 2'b01, 1'b0, 2, 1, '1, 512'h100, 1'b0, 1'b0, resp);
    check_eq("t5_bresp_err", DATA_W'(resp), 2);
    axi_read(64'h500, 8'd1, 1'b0, 1'b0, nb);
    check_eq("t5_word20", rd_data[0], 512'h100);
    check_eq("t5_word21", rd_data[1], 512'h101);
    check_eq("t5_rresp", DATA_W'(rd_resp[1]), 0);

    // Throttled len-15 read overlapped with a throttled len-15 write.
    axi_write(64'(200) << 6, 8'd15, 2'b01, 1'b0, 16, 15, '1, 512'h300, 1'b0, 1'b0, resp);
    fork
      axi_write(64'(100) << 6, 8'd15, 2'b01, 1'b1, 16, 15, '1, 512'h200, 1'b0, 1'b1, resp_w);
      axi_read(64'(200) << 6, 8'd15, 1'b1, 1'b0, nb_r);
    join
    check_eq("t6_bresp", DATA_W'(resp_w), 0);
    check_eq("t6_rd_nbeats", DATA_W'(nb_r), 16);
    for (int k = 0; k < 16; k++) begin
      exp_d = 512'h300 + DATA_W'(k);
      check_eq($sformatf("t6_rdata%0d", k), rd_data[k], exp_d);
    end
    axi_read(64'(100) << 6, 8'd15, 1'b0, 1'b0, nb);
    check_eq("t6_wr_nbeats", DATA_W'(nb), 16);
    for (int k = 0; k < 16; k++) begin
      exp_d = 512'h200 + DATA_W'(k);
      check_eq($sformatf("t6_wdata%0d", k), rd_data[k], exp_d);
    end

    // Reset asserted while beat 2 of an 8-beat read is on the bus.
    arid = 1'b0; araddr = 64'(200) << 6; arlen = 8'd7; arburst = 2'b01; arsize = 3'b110;
    arvalid = 1'b1;
    t = 0;
    while (!arready && t < 50) begin tick(); t++; end
    tick();
    arvalid = 1'b0;
    rready = 1'b1;
    nb = 0; t = 0;
    while (nb < 2 && t < 50) begin
      if (rvalid && rready) begin
        exp_d = 512'h300 + DATA_W'(nb);
        check_eq($sformatf("t7_pre_rdata%0d", nb), rdata, exp_d);
        nb++;
      end
      tick();
      t++;
    end
    check_eq("t7_pre_nbeats", DATA_W'(nb), 2);
    check_eq("t7_beat2_valid", DATA_W'(rvalid), 1);
    aresetn = 1'b0;
    #1;
    check_eq("t7_rst_rvalid", DATA_W'(rvalid), 0);
    check_eq("t7_rst_rlast",  DATA_W'(rlast), 0);
    check_eq("t7_rst_rdata",  rdata, 0);
    check_eq("t7_rst_arready", DATA_W'(arready), 0);
    rready = 1'b0;
    repeat (2) tick();
    aresetn = 1'b1;
    tick();
    check_eq("t7_arready_first_edge", DATA_W'(arready), 1);
    axi_read(64'h40, 8'd0, 1'b0, 1'b1, nb);
    check_eq("t7_after_nbeats", DATA_W'(nb), 1);
    check_eq("t7_after_rdata", rd_data[0], 512'd1);
    axi_read(64'(200) << 6, 8'd7, 1'b0, 1'b0, nb);
    check_eq("t7_mem_kept", rd_data[7], 512'h307);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
